// File: rtl/serial_magnitude_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_magnitude_compare_ctrl
// Purpose  : Compares two WIDTH-bit unsigned operands one 2-bit digit per
//            clock, MSB digit first, using a single time-shared digit
//            comparator. Results are registered greater/equal/less flags
//            behind a start/busy/done handshake.
// Ports    : clk              - rising-edge clock
//            reset            - asynchronous active-high reset, clears all state
//            start            - request, accepted only while idle
//            A, B             - operands, sampled only when start is accepted
//            busy             - high while digits are being compared
//            done             - one-cycle pulse, result flags valid
//            A_greater_than_B - result flag (A >  B)
//            A_equal_B        - result flag (A == B)
//            A_less_than_B    - result flag (A <  B)
// Params   : WIDTH      - operand width, even and >= 2
//            EARLY_EXIT - 1: stop at first differing digit
//                         0: always scan every digit (fixed latency)
// Revision : 1.0 - initial release
// ============================================================================
module serial_magnitude_compare_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             A_greater_than_B,
  output logic             A_equal_B,
  output logic             A_less_than_B
);

  localparam int c_digits = WIDTH / 2;
  // Keep the counter at least one bit wide so a single-digit build still
  // elaborates cleanly.
  localparam int c_cnt_w  = (c_digits > 1) ? $clog2(c_digits) : 1;
  localparam logic [c_cnt_w-1:0] c_last_digit = c_cnt_w'(c_digits - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_a_sh;
  logic [WIDTH-1:0]     r_b_sh;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_decided;

  logic [1:0]           w_a_dig;
  logic [1:0]           w_b_dig;
  logic                 w_gt;
  logic                 w_lt;

  // The digit under test is always the top two bits of the shift registers.
  assign w_a_dig = r_a_sh[WIDTH-1 -: 2];
  assign w_b_dig = r_b_sh[WIDTH-1 -: 2];

  // 2-bit magnitude comparator slice.
  assign w_gt = (w_a_dig[1] & ~w_b_dig[1])
              | (w_a_dig[1] &  w_a_dig[0] & ~w_b_dig[0])
              | (w_a_dig[0] & ~w_b_dig[1] & ~w_b_dig[0]);
  assign w_lt = (w_b_dig[1] & ~w_a_dig[1])
              | (w_b_dig[1] &  w_b_dig[0] & ~w_a_dig[0])
              | (w_b_dig[0] & ~w_a_dig[1] & ~w_a_dig[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_a_sh           <= '0;
      r_b_sh           <= '0;
      r_cnt            <= '0;
      r_decided        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      A_greater_than_B <= 1'b0;
      A_equal_B        <= 1'b0;
      A_less_than_B    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a_sh           <= A;
            r_b_sh           <= B;
            r_cnt            <= c_last_digit;
            r_decided        <= 1'b0;
            A_greater_than_B <= 1'b0;
            A_equal_B        <= 1'b0;
            A_less_than_B    <= 1'b0;
            busy             <= 1'b1;
            r_state          <= ST_COMPARE;
          end
        end

        ST_COMPARE: begin
          if (EARLY_EXIT) begin
            if (w_gt || w_lt || (r_cnt == '0)) begin
              A_greater_than_B <= w_gt;
              A_less_than_B    <= w_lt;
              A_equal_B        <= ~w_gt & ~w_lt;
              busy             <= 1'b0;
              done             <= 1'b1;
              r_state          <= ST_DONE;
            end else begin
              r_a_sh <= r_a_sh << 2;
              r_b_sh <= r_b_sh << 2;
              r_cnt  <= r_cnt - 1'b1;
            end
          end else begin
            // Only the first differing digit decides; later digits are
            // still scanned so the latency is always the full digit count.
            if (!r_decided && (w_gt || w_lt)) begin
              A_greater_than_B <= w_gt;
              A_less_than_B    <= w_lt;
              r_decided        <= 1'b1;
            end
            if (r_cnt == '0) begin
              if (!r_decided && !w_gt && !w_lt) begin
                A_equal_B <= 1'b1;
              end
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_a_sh <= r_a_sh << 2;
              r_b_sh <= r_b_sh << 2;
              r_cnt  <= r_cnt - 1'b1;
            end
          end
        end

        ST_DONE: begin
          // start is deliberately ignored here; it is only seen in idle.
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_magnitude_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_magnitude_compare_ctrl
// Purpose  : Self-checking bench for serial_magnitude_compare_ctrl. Two
//            instances (early-exit and fixed-latency) share the stimulus and
//            are checked against a digit-scan reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_magnitude_compare_ctrl;

  localparam int c_width  = 8;
  localparam int c_digits = c_width / 2;

  logic               clk;
  logic               reset;
  logic               start;
  logic [c_width-1:0] A;
  logic [c_width-1:0] B;

  logic busy_e1, done_e1, gt_e1, eq_e1, lt_e1;
  logic busy_e0, done_e0, gt_e0, eq_e0, lt_e0;

  int n_vec;
  int n_err;

  logic [c_width-1:0] op_a [0:127];
  logic [c_width-1:0] op_b [0:127];

  serial_magnitude_compare_ctrl #(.WIDTH(c_width), .EARLY_EXIT(1'b1)) dut_e1 (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .A                (A),
    .B                (B),
    .busy             (busy_e1),
    .done             (done_e1),
    .A_greater_than_B (gt_e1),
    .A_equal_B        (eq_e1),
    .A_less_than_B    (lt_e1)
  );

  serial_magnitude_compare_ctrl #(.WIDTH(c_width), .EARLY_EXIT(1'b0)) dut_e0 (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .A                (A),
    .B                (B),
    .busy             (busy_e0),
    .done             (done_e0),
    .A_greater_than_B (gt_e0),
    .A_equal_B        (eq_e0),
    .A_less_than_B    (lt_e0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: ordinary unsigned comparison gives the flags {gt,eq,lt}.
  function automatic logic [2:0] ref_flags(input logic [c_width-1:0] a,
                                           input logic [c_width-1:0] b);
    if (a > b)       return 3'b100;
    else if (a == b) return 3'b010;
    else             return 3'b001;
  endfunction

  // Reference latency: cycles from acceptance edge to the edge after which
  // done is high.
  function automatic int ref_lat(input logic [c_width-1:0] a,
                                 input logic [c_width-1:0] b,
                                 input bit early);
    int da, db;
    if (!early) return c_digits;
    for (int k = 0; k < c_digits; k++) begin
      da = int'((a >> (2 * (c_digits - 1 - k))) & 3);
      db = int'((b >> (2 * (c_digits - 1 - k))) & 3);
      if (da != db) return k + 1;
    end
    return c_digits;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One request with start pulsed for a single cycle; operands are
  // scrambled right after acceptance to show they were latched.
  task automatic run_op(input logic [c_width-1:0] a, input logic [c_width-1:0] b);
    int lat1, lat0, nd1, nd0;
    lat1 = 0; lat0 = 0; nd1 = 0; nd0 = 0;
    @(negedge clk);
    start = 1'b1; A = a; B = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; A = c_width'($urandom); B = c_width'($urandom);
    check_val("accept_busy", {30'd0, busy_e1, busy_e0}, 32'h3);
    check_val("accept_flags_clr", {26'd0, gt_e1, eq_e1, lt_e1, gt_e0, eq_e0, lt_e0}, 32'h0);
    for (int n = 1; n <= c_digits + 3; n++) begin
      @(posedge clk);
      @(negedge clk);
      A = c_width'($urandom); B = c_width'($urandom);
      if (busy_e1 && done_e1) check_val("overlap_e1", 32'd1, 32'd0);
      if (busy_e0 && done_e0) check_val("overlap_e0", 32'd1, 32'd0);
      if (busy_e1) check_val("busy_flags_e1", {29'd0, gt_e1, eq_e1, lt_e1}, 32'd0);
      if (done_e1) begin
        nd1++;
        if (lat1 == 0) lat1 = n;
        check_val("flags_e1", {29'd0, gt_e1, eq_e1, lt_e1}, {29'd0, ref_flags(a, b)});
      end
      if (done_e0) begin
        nd0++;
        if (lat0 == 0) lat0 = n;
        check_val("flags_e0", {29'd0, gt_e0, eq_e0, lt_e0}, {29'd0, ref_flags(a, b)});
      end
    end
    check_val("latency_e1", lat1, ref_lat(a, b, 1'b1));
    check_val("latency_e0", lat0, ref_lat(a, b, 1'b0));
    check_val("done_pulses_e1", nd1, 1);
    check_val("done_pulses_e0", nd0, 1);
    check_val("idle_busy", {30'd0, busy_e1, busy_e0}, 32'h0);
  endtask

  initial begin
    int acc1, acc0, nres1, nres0;
    logic [c_width-1:0] ra, rb;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #12;
    check_val("reset_outs", {22'd0, busy_e1, done_e1, gt_e1, eq_e1, lt_e1,
                             busy_e0, done_e0, gt_e0, eq_e0, lt_e0}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases.
    run_op(8'hB4, 8'h74);
    run_op(8'h5C, 8'h5D);
    run_op(8'hA5, 8'hA5);
    // Equal flag must persist through idle cycles until the next start.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("eq_hold", {26'd0, gt_e1, eq_e1, lt_e1, gt_e0, eq_e0, lt_e0}, 32'h12);
    end
    run_op(8'hC0, 8'h00);
    run_op(8'h00, 8'hFF);
    run_op(8'hFF, 8'hFE);

    // Randomized cases, biased toward equal and shared-prefix operands.
    for (int i = 0; i < 40; i++) begin
      ra = c_width'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ c_width'(1 << $urandom_range(0, c_width - 1));
        default: rb = c_width'($urandom);
      endcase
      run_op(ra, rb);
    end

    // Reset in the middle of a comparison aborts it.
    @(negedge clk);
    start = 1'b1; A = 8'h12; B = 8'h13;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("midreset_outs", {22'd0, busy_e1, done_e1, gt_e1, eq_e1, lt_e1,
                                busy_e0, done_e0, gt_e0, eq_e0, lt_e0}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < c_digits + 3; n++) begin
      @(negedge clk);
      check_val("post_reset_quiet", {26'd0, busy_e1, done_e1, busy_e0, done_e0,
                                     eq_e1, eq_e0}, 32'h0);
    end

    // Back-to-back with start held and operands changing every cycle.
    do_reset();
    ra = c_width'($urandom);
    rb = c_width'($urandom);
    start = 1'b1; A = ra; B = rb;
    op_a[1] = ra; op_b[1] = rb;
    acc1 = 1; acc0 = 1; nres1 = 0; nres0 = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy_e1 && done_e1) check_val("b2b_overlap_e1", 32'd1, 32'd0);
      if (busy_e0 && done_e0) check_val("b2b_overlap_e0", 32'd1, 32'd0);
      if (done_e1) begin
        check_val("b2b_lat_e1", c, acc1 + ref_lat(op_a[acc1], op_b[acc1], 1'b1));
        check_val("b2b_flags_e1", {29'd0, gt_e1, eq_e1, lt_e1},
                  {29'd0, ref_flags(op_a[acc1], op_b[acc1])});
        acc1 = c + 2;
        nres1++;
      end
      if (done_e0) begin
        check_val("b2b_lat_e0", c, acc0 + ref_lat(op_a[acc0], op_b[acc0], 1'b0));
        check_val("b2b_flags_e0", {29'd0, gt_e0, eq_e0, lt_e0},
                  {29'd0, ref_flags(op_a[acc0], op_b[acc0])});
        acc0 = c + 2;
        nres0++;
      end
      ra = c_width'($urandom);
      rb = c_width'($urandom);
      A = ra; B = rb;
      op_a[c + 1] = ra; op_b[c + 1] = rb;
    end
    start = 1'b0;
    check_val("b2b_results_e1", 32'(nres1 > 0), 32'd1);
    check_val("b2b_results_e0", 32'(nres0 > 0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
